fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_ctrl.sv | 92 +++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-unit types and constants.
// Imported by the fetch controller and its neighbours.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   localparam int unsigned INSTR_BYTES      = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the imem address/stop pins and
// presents fetched words to decode over a valid/ready handshake.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned IMEM_WORDS = 2048
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic [31:0] o_imem_addr,
   output logic        o_imem_stop,
   input  logic [31:0] i_imem_data,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic        o_valid,
   input  logic        i_ready,
   output logic        o_fault,
   output logic [31:0] o_fetch_count
);

   // 33 bits so the byte limit cannot overflow for large memories
   localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) * 33'(INSTR_BYTES);

   function automatic logic legal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && ({1'b0, a} < LIMIT);
   endfunction

   fetch_state_e state_q;
   logic [31:0]  pc_q;
   logic [31:0]  resp_pc_q;
   logic         resp_valid_q;
   logic [31:0]  count_q;

   logic faulted;
   logic stop;
   logic handshake;

   assign faulted   = (state_q == FAULT);
   assign o_valid   = resp_valid_q & ~faulted;
   assign stop      = (o_valid & ~i_ready & ~i_redirect)
                    | (faulted & ~i_redirect);
   assign handshake = o_valid & i_ready;

   assign o_imem_addr   = pc_q;
   assign o_imem_stop   = stop;
   assign o_instr       = i_imem_data;
   assign o_pc          = resp_pc_q;
   assign o_fault       = faulted;
   assign o_fetch_count = count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         resp_pc_q    <= 32'd0;
         resp_valid_q <= 1'b0;
         count_q      <= 32'd0;
      end else begin
         if (handshake)
            count_q <= count_q + 32'd1;
         if (i_redirect) begin
            resp_valid_q <= 1'b0;
            if (legal(i_redirect_pc)) begin
               pc_q    <= i_redirect_pc;
               state_q <= RUN;
            end else begin
               state_q <= FAULT;
            end
         end else if (!stop) begin
            // BOOT is a single settling cycle; the first issue happens in RUN
            unique case (state_q)
               BOOT: state_q <= legal(pc_q) ? RUN : FAULT;
               RUN: begin
                  if (legal(pc_q)) begin
                     resp_pc_q    <= pc_q;
                     resp_valid_q <= 1'b1;
                     pc_q         <= pc_q + 32'd4;
                  end else begin
                     state_q      <= FAULT;
                     resp_valid_q <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
